// File: rtl/morse_stream_decoder.sv
// Morse key stream decoder: edge-detects dot/dash/char_end/word_end levels, decodes
// A-Z/0-9 to ASCII (plus optional word spaces) into a first-word-fall-through FIFO.
module morse_stream_decoder #(
  parameter int MAX_LEN    = 5,
  parameter int DEPTH      = 8,
  parameter bit EMIT_SPACE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dot,
  input  logic                     dash,
  input  logic                     char_end,
  input  logic                     word_end,
  output logic [7:0]               out_char,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     sym_err,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]         hist_q, hist_d;
  logic [3:0]         len_q, len_d;
  logic [MAX_LEN-1:0] code_q, code_d;
  logic               err_q, err_d;
  logic               gap_q, gap_d;
  logic               space_pend_q, space_pend_d;
  logic               stage_vld_q, stage_vld_d;
  logic               stage_bad_q, stage_bad_d;
  logic [7:0]         stage_data_q, stage_data_d;
  logic               sym_err_q, sym_err_d;
  logic               ovf_q, ovf_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [7:0]         mem [DEPTH];

  logic               dot_e, dash_e, ce_e, we_e, close, emit_space;
  logic [3:0]         len_a;
  logic [MAX_LEN-1:0] code_a;
  logic               err_a;
  logic [8:0]         look;
  logic               pop, room, push, push_space;
  logic [7:0]         push_data;

  // Code is read MSB-first as the keyed order, dot=0 dash=1; returns {hit, ascii}.
  function automatic logic [8:0] lookup(input logic [3:0] len, input logic [4:0] c);
    logic [7:0] ch;
    ch = 8'h00;
    case (len)
      4'd1: ch = c[0] ? "T" : "E";
      4'd2:
        case (c[1:0])
          2'b00:   ch = "I";
          2'b01:   ch = "A";
          2'b10:   ch = "N";
          default: ch = "M";
        endcase
      4'd3:
        case (c[2:0])
          3'b000:  ch = "S";
          3'b001:  ch = "U";
          3'b010:  ch = "R";
          3'b011:  ch = "W";
          3'b100:  ch = "D";
          3'b101:  ch = "K";
          3'b110:  ch = "G";
          default: ch = "O";
        endcase
      4'd4:
        case (c[3:0])
          4'b0000: ch = "H";
          4'b0001: ch = "V";
          4'b0010: ch = "F";
          4'b0100: ch = "L";
          4'b0110: ch = "P";
          4'b0111: ch = "J";
          4'b1000: ch = "B";
          4'b1001: ch = "X";
          4'b1010: ch = "C";
          4'b1011: ch = "Y";
          4'b1100: ch = "Z";
          4'b1101: ch = "Q";
          default: ch = 8'h00;
        endcase
      4'd5:
        case (c)
          5'b01111: ch = "1";
          5'b00111: ch = "2";
          5'b00011: ch = "3";
          5'b00001: ch = "4";
          5'b00000: ch = "5";
          5'b10000: ch = "6";
          5'b11000: ch = "7";
          5'b11100: ch = "8";
          5'b11110: ch = "9";
          5'b11111: ch = "0";
          default:  ch = 8'h00;
        endcase
      default: ch = 8'h00;
    endcase
    return {ch != 8'h00, ch};
  endfunction

  always_comb begin
    dot_e  = dot      & ~hist_q[0];
    dash_e = dash     & ~hist_q[1];
    ce_e   = char_end & ~hist_q[2];
    we_e   = word_end & ~hist_q[3];
    hist_d = {word_end, char_end, dash, dot};

    len_a  = len_q;
    code_a = code_q;
    err_a  = err_q;
    if (dot_e & dash_e) begin
      err_a = 1'b1;
    end else if (dot_e | dash_e) begin
      if (len_q == 4'(MAX_LEN)) begin
        err_a = 1'b1;
      end else begin
        code_a = {code_q[MAX_LEN-2:0], dash_e};
        len_a  = len_q + 4'd1;
      end
    end

    // A symbol keyed in the same cycle as a close belongs to the closing character.
    close        = ce_e | we_e;
    look         = lookup(len_a, code_a[4:0]);
    len_d        = len_a;
    code_d       = code_a;
    err_d        = err_a;
    stage_vld_d  = 1'b0;
    stage_bad_d  = 1'b0;
    stage_data_d = stage_data_q;
    if (close) begin
      len_d  = 4'd0;
      code_d = '0;
      err_d  = 1'b0;
      if ((len_a != 4'd0) || err_a) begin
        stage_vld_d  = 1'b1;
        stage_bad_d  = err_a | ~look[8];
        stage_data_d = (err_a | ~look[8]) ? 8'h3F : look[7:0];
      end
    end

    gap_d = gap_q;
    if (dot_e | dash_e) gap_d = 1'b0;
    if (we_e)           gap_d = 1'b1;
    emit_space = EMIT_SPACE && we_e && (!gap_q || (len_a != 4'd0) || err_a);

    // Staged characters win the write port; a blocked space waits rather than drops.
    pop        = (count_q != '0) & out_ready;
    room       = (count_q != CW'(DEPTH)) | pop;
    push_space = ~stage_vld_q & space_pend_q & room;
    push       = (stage_vld_q & room) | push_space;
    push_data  = stage_vld_q ? stage_data_q : 8'h20;

    space_pend_d = (space_pend_q & ~push_space) | emit_space;
    ovf_d        = ovf_q | (stage_vld_q & ~room);
    sym_err_d    = stage_vld_q & stage_bad_q;
    wr_ptr_d     = wr_ptr_q + AW'(push);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    count_d      = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q       <= '0;
      len_q        <= '0;
      code_q       <= '0;
      err_q        <= 1'b0;
      gap_q        <= 1'b0;
      space_pend_q <= 1'b0;
      stage_vld_q  <= 1'b0;
      stage_bad_q  <= 1'b0;
      stage_data_q <= '0;
      sym_err_q    <= 1'b0;
      ovf_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      hist_q       <= hist_d;
      len_q        <= len_d;
      code_q       <= code_d;
      err_q        <= err_d;
      gap_q        <= gap_d;
      space_pend_q <= space_pend_d;
      stage_vld_q  <= stage_vld_d;
      stage_bad_q  <= stage_bad_d;
      stage_data_q <= stage_data_d;
      sym_err_q    <= sym_err_d;
      ovf_q        <= ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign out_valid  = count_q != '0;
  assign out_char   = out_valid ? mem[rd_ptr_q] : 8'h00;
  assign fifo_count = count_q;
  assign sym_err    = sym_err_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_morse_stream_decoder.sv
// Directed self-checking bench for morse_stream_decoder: decode table, word spaces,
// error characters, FIFO overflow and mid-character reset.
module tb_morse_stream_decoder;
  localparam logic [3:0] K_DOT  = 4'b0001;
  localparam logic [3:0] K_DASH = 4'b0010;
  localparam logic [3:0] K_CE   = 4'b0100;
  localparam logic [3:0] K_WE   = 4'b1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dot = 1'b0, dash = 1'b0, char_end = 1'b0, word_end = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_char;
  logic       out_valid;
  logic [3:0] fifo_count;
  logic       sym_err, overflow;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int sym_cnt = 0;
  logic [7:0] beats[$];
  int stamps[$];

  morse_stream_decoder #(.MAX_LEN(5), .DEPTH(8), .EMIT_SPACE(1'b1)) dut (
    .clk(clk), .rst(rst), .dot(dot), .dash(dash), .char_end(char_end),
    .word_end(word_end), .out_char(out_char), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_count(fifo_count), .sym_err(sym_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Record every accepted beat and every sym_err cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      beats.push_back(out_char);
      stamps.push_back(cycle);
    end
    if (sym_err) sym_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] k);
    {word_end, char_end, dash, dot} = k;
    tick();
    {word_end, char_end, dash, dot} = 4'b0000;
    tick();
  endtask

  task automatic test_reset();
    total++; if (out_char !== 8'h00) begin bad++; $display("[TB] FAIL reset_out_char got=%h exp=00", out_char); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("[TB] FAIL reset_fifo_count got=%0d exp=0", fifo_count); end
    total++; if (sym_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_sym_err got=%b exp=0", sym_err); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_single_e();
    beats.delete(); stamps.delete(); sym_cnt = 0;
    out_ready = 1'b0;
    send(K_DOT);
    char_end = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL e_valid_at_close got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL e_valid_after_write got=%b exp=1", out_valid); end
    total++; if (out_char !== 8'h45) begin bad++; $display("[TB] FAIL e_out_char got=%h exp=45", out_char); end
    total++; if (fifo_count !== 4'd1) begin bad++; $display("[TB] FAIL e_fifo_count got=%0d exp=1", fifo_count); end
    char_end = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    total++; if (fifo_count !== 4'd0) begin bad++; $display("[TB] FAIL e_drained got=%0d exp=0", fifo_count); end
    total++; if (beats.size() !== 1) begin bad++; $display("[TB] FAIL e_beat_count got=%0d exp=1", beats.size()); end
    else begin
      total++; if (beats[0] !== 8'h45) begin bad++; $display("[TB] FAIL e_beat got=%h exp=45", beats[0]); end
    end
    total++; if (sym_cnt !== 0) begin bad++; $display("[TB] FAIL e_sym_err got=%0d exp=0", sym_cnt); end
  endtask

  task automatic test_sequence();
    logic [7:0] exp_q[$];
    exp_q = '{8'h41, 8'h4F, 8'h30, 8'h35};
    beats.delete(); stamps.delete();
    out_ready = 1'b1;
    send(K_DOT); send(K_DASH); send(K_CE);
    repeat (3) send(K_DASH); send(K_CE);
    repeat (5) send(K_DASH); send(K_CE);
    repeat (5) send(K_DOT); send(K_CE);
    repeat (4) tick();
    total++; if (beats.size() !== 4) begin bad++; $display("[TB] FAIL seq_beat_count got=%0d exp=4", beats.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (beats[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL seq_beat%0d got=%h exp=%h", i, beats[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_word_space();
    beats.delete(); stamps.delete();
    out_ready = 1'b1;
    dash = 1'b1;
    repeat (3) tick();
    dash = 1'b0;
    tick();
    send(K_DOT); send(K_DASH); send(K_DOT); send(K_WE);
    repeat (4) tick();
    total++; if (beats.size() !== 2) begin bad++; $display("[TB] FAIL word_beat_count got=%0d exp=2", beats.size()); end
    else begin
      total++; if (beats[0] !== 8'h43) begin bad++; $display("[TB] FAIL word_char got=%h exp=43", beats[0]); end
      total++; if (beats[1] !== 8'h20) begin bad++; $display("[TB] FAIL word_space got=%h exp=20", beats[1]); end
      total++;
      if (stamps[1] - stamps[0] !== 1) begin bad++; $display("[TB] FAIL word_back_to_back got=%0d exp=1", stamps[1] - stamps[0]); end
    end
    send(K_WE);
    repeat (4) tick();
    total++; if (beats.size() !== 2) begin bad++; $display("[TB] FAIL word_second_gap got=%0d exp=2", beats.size()); end
  endtask

  task automatic test_errors();
    beats.delete(); stamps.delete(); sym_cnt = 0;
    out_ready = 1'b1;
    repeat (6) send(K_DOT);
    send(K_CE);
    repeat (3) tick();
    total++; if (sym_cnt !== 1) begin bad++; $display("[TB] FAIL err_long_pulse got=%0d exp=1", sym_cnt); end
    send(K_DOT | K_DASH); send(K_CE);
    send(K_DOT); send(K_DOT); send(K_DASH); send(K_DASH); send(K_CE);
    send(K_DOT); send(K_CE);
    repeat (4) tick();
    total++; if (sym_cnt !== 3) begin bad++; $display("[TB] FAIL err_pulse_total got=%0d exp=3", sym_cnt); end
    total++; if (beats.size() !== 4) begin bad++; $display("[TB] FAIL err_beat_count got=%0d exp=4", beats.size()); end
    else begin
      total++; if (beats[0] !== 8'h3F) begin bad++; $display("[TB] FAIL err_too_long got=%h exp=3f", beats[0]); end
      total++; if (beats[1] !== 8'h3F) begin bad++; $display("[TB] FAIL err_collision got=%h exp=3f", beats[1]); end
      total++; if (beats[2] !== 8'h3F) begin bad++; $display("[TB] FAIL err_no_match got=%h exp=3f", beats[2]); end
      total++; if (beats[3] !== 8'h45) begin bad++; $display("[TB] FAIL err_recover got=%h exp=45", beats[3]); end
    end
  endtask

  task automatic test_overflow();
    beats.delete(); stamps.delete();
    out_ready = 1'b0;
    repeat (9) begin send(K_DOT); send(K_CE); end
    repeat (2) tick();
    total++; if (fifo_count !== 4'd8) begin bad++; $display("[TB] FAIL ovf_count got=%0d exp=8", fifo_count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag got=%b exp=1", overflow); end
    total++; if (out_char !== 8'h45) begin bad++; $display("[TB] FAIL ovf_head_hold got=%h exp=45", out_char); end
    out_ready = 1'b1;
    repeat (12) tick();
    total++; if (beats.size() !== 8) begin bad++; $display("[TB] FAIL ovf_beats got=%0d exp=8", beats.size()); end
    for (int i = 0; i < beats.size(); i++) begin
      total++;
      if (beats[i] !== 8'h45) begin bad++; $display("[TB] FAIL ovf_beat%0d got=%h exp=45", i, beats[i]); end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sticky got=%b exp=1", overflow); end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("[TB] FAIL ovf_drained got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(K_DOT); send(K_DOT); send(K_CE);
    send(K_DOT); send(K_DASH);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    beats.delete(); stamps.delete();
    total++; if (fifo_count !== 4'd0) begin bad++; $display("[TB] FAIL mid_fifo_count got=%0d exp=0", fifo_count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_out_valid got=%b exp=0", out_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL mid_overflow got=%b exp=0", overflow); end
    out_ready = 1'b1;
    send(K_DASH); send(K_DOT); send(K_DASH); send(K_DOT); send(K_CE);
    repeat (4) tick();
    total++; if (beats.size() !== 1) begin bad++; $display("[TB] FAIL mid_beat_count got=%0d exp=1", beats.size()); end
    else begin
      total++; if (beats[0] !== 8'h43) begin bad++; $display("[TB] FAIL mid_beat got=%h exp=43", beats[0]); end
    end
  endtask

  initial begin
    rst = 1'b0;
    tick(); tick();
    test_reset();
    rst = 1'b1;
    tick();
    test_single_e();
    test_sequence();
    test_word_space();
    test_errors();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_stream_decoder.md
Name: morse_stream_decoder

Overview:
- Parametrised successor to the single-character Morse decoder.
- Accepts level-style dot/dash/char_end/word_end key inputs and edge-detects them internally.
- Accumulates up to MAX_LEN symbols and decodes A–Z and 0–9 to uppercase ASCII, with optional word-gap spaces.
- Buffers decoded characters in a DEPTH-entry FIFO drained by a valid/ready consumer (UART/LCD writer).

Parameters:
- MAX_LEN, 5, maximum symbols per character; legal range 5..8. Codes longer than 5 never match the table.
- DEPTH, 8, output FIFO entries; power of two, ≥2.
- EMIT_SPACE, 1, when 1 a word_end edge enqueues 0x20; when 0 word_end only closes the pending character.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- dot  in  1  dot key level; a rising edge appends '.'.
- dash  in  1  dash key level; a rising edge appends '-'.
- char_end  in  1  level; a rising edge closes the current character.
- word_end  in  1  level; a rising edge closes the character, then enqueues a space.
- out_char  out  8  ASCII at the FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accept; pop when out_valid & out_ready.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- sym_err  out  1  one-cycle pulse when a character decodes to '?'.
- overflow  out  1  sticky: a write was dropped because the FIFO was full; cleared only by rst.

Behaviour:
- Reset (rst low, asynchronous):
  - Outputs: out_char=0x00, out_valid=0, fifo_count=0, sym_err=0, overflow=0.
  - Internal: symbol length=0, code shift register=0, error flag=0, space_pending=0, edge-detect history=0.
  - rst low mid-character discards all accumulated symbols and all FIFO contents.
- Edge detection: each input is registered once; an edge at sample edge k means the input is high at k and was low at k-1. Held levels produce exactly one event.
- Symbol accumulation:
  - A dot edge shifts in 0 and a dash edge shifts in 1, LSB = latest symbol; length increments.
  - Dot and dash edges in the same cycle: the symbol is discarded and the char error flag is set.
  - A symbol arriving when length==MAX_LEN is not stored and sets the char error flag.
- Character close, on a char_end edge or word_end edge:
  - A dot/dash edge in the same cycle is appended first, then the character closes.
  - If length==0 and the error flag is clear, nothing is written.
  - Otherwise (length, code) is looked up: standard ITU A–Z (lengths 1..4) and 0–9 (length 5).
  - No match, or error flag set: write 0x3F ('?') and pulse sym_err at edge k+1.
  - After close, length, code and error flag are cleared.
- Latency: close edge at k → FIFO write at edge k+1 → out_valid/out_char valid after edge k+1 when the FIFO was empty (first-word fall-through).
- word_end with EMIT_SPACE=1:
  - Sets space_pending; the space is written one cycle after the character write.
  - If no character was pending, the space is written at k+1.
  - Consecutive word_end edges with no symbols between them produce no further spaces (at most one space per gap).
- FIFO:
  - Circular buffer; pointers wrap at DEPTH.
  - Simultaneous push and pop when full or empty is legal; fifo_count is unchanged when both occur on a non-empty FIFO.
  - Push when full and no pop the same cycle: data is dropped and overflow is set.
  - A pending space stays pending (it is not dropped) until a slot frees.
  - out_char holds steady while out_valid=1 and out_ready=0.
- Simultaneous char_end and word_end edges are treated as word_end.

Test Plan:
- Reset then dot, char_end, with out_ready=1 → one beat out_char=0x45 ('E'); sym_err=0; fifo_count returns to 0.
- dot, dash, char_end (A); dash ×3, char_end (O); 5 dashes, char_end (0) → beats 0x41, 0x4F, 0x30 in order.
- dash held 3 cycles, then dot, dash, dot, word_end (C + space) → 0x43 then 0x20 in consecutive writes. A second word_end with no symbols → no extra beat.
- 6 dots with MAX_LEN=5, then char_end → 0x3F with sym_err pulsed once. Dot and dash rising together, then char_end → 0x3F.
- out_ready=0, DEPTH=8, nine 'E' characters → fifo_count=8, overflow=1. Then out_ready=1 → exactly 8 beats of 0x45; overflow stays 1.
- dot, dash, then rst low for 1 cycle mid-sequence, then dash, dot, dash, dot, char_end → FIFO empty right after reset; single beat 0x43 ('C'), no 'A' emitted.
